turbo_iter_ctrl: RTL

TURBO_ITER_CTRL -- requirements
Module: turbo_iter_ctrl

---
 rtl/turbo_iter_ctrl.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/turbo_iter_ctrl.sv
// Turbo decoder iteration controller.
// Collects one frame of {sys, par1, par2} symbols, then alternates launches of an
// external SISO decoder between natural order (DEC1) and interleaved order (DEC2).
// Extrinsic information is exchanged through two stores until the hard decisions
// of both decoders agree or the iteration limit is reached.
module turbo_iter_ctrl #(
  parameter int               N        = 5,
  parameter int               CW       = 4,
  parameter int               LW       = 10,
  parameter int               MAX_ITER = 16,
  parameter logic [8*N-1:0]   PERM     = {8'd3, 8'd1, 8'd2, 8'd4, 8'd0}
) (
  input  logic              clk_p_i,
  input  logic              reset_n_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [3*CW-1:0]   in_data_i,
  output logic              siso_start_o,
  output logic              siso_sel_o,
  output logic [N*CW-1:0]   siso_sys_o,
  output logic [N*CW-1:0]   siso_par_o,
  output logic [N*LW-1:0]   siso_apr_o,
  input  logic [N*LW-1:0]   siso_llr_i,
  input  logic              siso_done_i,
  output logic [N-1:0]      data_o,
  output logic              done_o,
  output logic [5:0]        iter_o,
  output logic              early_o
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  // Two guard bits keep llr - apr - 2*sys exact before saturation.
  localparam int XW = LW + 2;
  localparam logic signed [XW-1:0] SAT_HI = XW'((2 ** (LW - 1)) - 1);
  localparam logic signed [XW-1:0] SAT_LO = -SAT_HI - XW'(1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_DEC1,
    S_DEC2,
    S_FINISH
  } state_e;

  typedef logic [N-1:0][CW-1:0] sym_vec_t;
  typedef logic [N-1:0][LW-1:0] llr_vec_t;

  // Interleaver entry k lives at PERM bits 8k+7:8k.
  function automatic logic [IW-1:0] pi_of(input int k);
    return IW'(PERM[8*k +: 8]);
  endfunction

  function automatic logic [LW-1:0] sat(input logic signed [XW-1:0] v);
    logic signed [XW-1:0] r;
    if (v > SAT_HI)      r = SAT_HI;
    else if (v < SAT_LO) r = SAT_LO;
    else                 r = v;
    return r[LW-1:0];
  endfunction

  function automatic logic [LW-1:0] ext_calc(input logic [LW-1:0] llr,
                                             input logic [LW-1:0] apr,
                                             input logic [CW-1:0] sys);
    logic signed [XW-1:0] diff;
    diff = XW'(signed'(llr)) - XW'(signed'(apr)) - (XW'(signed'(sys)) <<< 1);
    return sat(diff);
  endfunction

  // Positive (and zero) soft values decide for bit 1.
  function automatic logic [N-1:0] hard_vec(input llr_vec_t v);
    logic [N-1:0] b;
    for (int k = 0; k < N; k++) b[k] = ~v[k][LW-1];
    return b;
  endfunction

  state_e   state_q, state_d;
  logic [IW-1:0] beat_q, beat_d;
  logic [5:0]    iter_q, iter_d;
  sym_vec_t sys_q, sys_d, par1_q, par1_d, par2_q, par2_d;
  llr_vec_t ext1_q, ext1_d, ext2_q, ext2_d;
  logic     start_q, start_d;
  sym_vec_t sys_out_q, sys_out_d, par_out_q, par_out_d;
  llr_vec_t apr_out_q, apr_out_d;
  logic [N-1:0] data_q, data_d;
  logic [5:0]   iter_out_q, iter_out_d;
  logic         early_q, early_d;

  llr_vec_t ext_new;
  logic     acc_done;

  assign in_ready_o   = (state_q == S_LOAD) && reset_n_i;
  assign siso_start_o = start_q;
  assign siso_sel_o   = (state_q == S_DEC2);
  assign siso_sys_o   = sys_out_q;
  assign siso_par_o   = par_out_q;
  assign siso_apr_o   = apr_out_q;
  assign data_o       = data_q;
  assign done_o       = (state_q == S_FINISH);
  assign iter_o       = iter_out_q;
  assign early_o      = early_q;

  // Next-state, store updates and SISO launch vectors.
  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_d    = state_q;
    beat_d     = beat_q;
    iter_d     = iter_q;
    sys_d      = sys_q;
    par1_d     = par1_q;
    par2_d     = par2_q;
    ext1_d     = ext1_q;
    ext2_d     = ext2_q;
    start_d    = 1'b0;
    sys_out_d  = sys_out_q;
    par_out_d  = par_out_q;
    apr_out_d  = apr_out_q;
    data_d     = data_q;
    iter_out_d = iter_out_q;
    early_d    = early_q;

    // Result position k always pairs with the apr/sys this SISO was launched with.
    ext_new = '0;
    for (int k = 0; k < N; k++) begin
      ext_new[k] = ext_calc(siso_llr_i[LW*k +: LW], apr_out_q[k], sys_out_q[k]);
    end
    // A done coinciding with the launch pulse belongs to no current request.
    acc_done = siso_done_i && !start_q;

    unique case (state_q)
      S_LOAD: begin
        if (in_valid_i) begin
          sys_d[beat_q]  = in_data_i[3*CW-1:2*CW];
          par1_d[beat_q] = in_data_i[2*CW-1:CW];
          par2_d[beat_q] = in_data_i[CW-1:0];
          if (beat_q == IW'(N - 1)) begin
            beat_d  = '0;
            iter_d  = '0;
            ext1_d  = '0;
            ext2_d  = '0;
            state_d = S_DEC1;
          end else begin
            beat_d = beat_q + IW'(1);
          end
        end
      end
      S_DEC1: begin
        if (acc_done) begin
          ext1_d  = ext_new;
          state_d = S_DEC2;
        end
      end
      S_DEC2: begin
        if (acc_done) begin
          for (int k = 0; k < N; k++) ext2_d[pi_of(k)] = ext_new[k];
          iter_d = iter_q + 6'd1;
          if (hard_vec(ext1_q) == hard_vec(ext2_d)) begin
            early_d = 1'b1;
            state_d = S_FINISH;
          end else if (iter_d == 6'(MAX_ITER)) begin
            early_d = 1'b0;
            state_d = S_FINISH;
          end else begin
            state_d = S_DEC1;
          end
          // Results are published on entry so they are valid alongside done_o.
          if (state_d == S_FINISH) begin
            data_d     = hard_vec(ext2_d);
            iter_out_d = iter_d;
          end
        end
      end
      S_FINISH: begin
        state_d = S_LOAD;
      end
      default: state_d = S_LOAD;
    endcase

    // Launch vectors are captured on the entering edge and held for the whole state.
    if (state_d != state_q) begin
      if (state_d == S_DEC1) begin
        start_d = 1'b1;
        for (int k = 0; k < N; k++) begin
          sys_out_d[k] = sys_d[k];
          par_out_d[k] = par1_d[k];
          apr_out_d[k] = ext2_d[k];
        end
      end else if (state_d == S_DEC2) begin
        start_d = 1'b1;
        for (int k = 0; k < N; k++) begin
          sys_out_d[k] = sys_d[pi_of(k)];
          par_out_d[k] = par2_d[k];
          apr_out_d[k] = ext1_d[pi_of(k)];
        end
      end
    end
  end

  // State and store registers with asynchronous active-low reset.
  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      // NOTE: the symbol and extrinsic stores are flop vectors, not RAM, so they are
      // cleared by reset like every other register and a fresh frame starts clean.
      state_q    <= S_LOAD;
      beat_q     <= '0;
      iter_q     <= '0;
      sys_q      <= '0;
      par1_q     <= '0;
      par2_q     <= '0;
      ext1_q     <= '0;
      ext2_q     <= '0;
      start_q    <= 1'b0;
      sys_out_q  <= '0;
      par_out_q  <= '0;
      apr_out_q  <= '0;
      data_q     <= '0;
      iter_out_q <= '0;
      early_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      state_q    <= state_d;
      beat_q     <= beat_d;
      iter_q     <= iter_d;
      sys_q      <= sys_d;
      par1_q     <= par1_d;
      par2_q     <= par2_d;
      ext1_q     <= ext1_d;
      ext2_q     <= ext2_d;
      start_q    <= start_d;
      sys_out_q  <= sys_out_d;
      par_out_q  <= par_out_d;
      apr_out_q  <= apr_out_d;
      data_q     <= data_d;
      iter_out_q <= iter_out_d;
      early_q    <= early_d;
    end
  end

endmodule
